// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: two valid/ready writeback requesters, registered write.
// Optional macro RF_ZERO_GUARD_EN suppresses writes to register 0.
module rf_write_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              last_grant_q, last_grant_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              both;
  logic              gnt0, gnt1, xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              addr_ok;

  assign both = req0_valid & req1_valid;

  // Grant decision: ties go to fixed priority or away from last winner
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && !flush) begin
      if (both) begin
        if (PRIO_MODE != 0 || last_grant_q) gnt0 = 1'b1;
        else                                gnt1 = 1'b1;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign xfer     = gnt0 | gnt1;
  assign sel_addr = gnt1 ? req1_addr : req0_addr;
  assign sel_data = gnt1 ? req1_data : req0_data;

`ifdef RF_ZERO_GUARD_EN
  assign addr_ok = (sel_addr != '0);
`else
  assign addr_ok = 1'b1;
`endif

  // Next-state for grant history, staged write and conflict counter
  always_comb begin
    last_grant_d = last_grant_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    cnt_d        = cnt_q;
    if (xfer) begin
      last_grant_d = gnt1;
      reg_write_d  = addr_ok;
      write_reg_d  = sel_addr;
      write_data_d = sel_data;
    end
    if (both && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req0_ready   = gnt0;
  assign req1_ready   = gnt1;
  assign reg_write    = reg_write_q;
  assign write_reg    = write_reg_q;
  assign write_data   = write_data_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: round-robin/CNT_W=4 and fixed-priority instances.
// Scoreboard of expected registered outputs, popped one cycle after drive.
module tb_rf_write_arbiter;

  typedef struct {
    logic        rw;
    logic [5:0]  wr;
    logic [31:0] wd;
    logic [15:0] cnt;
  } exp_t;

`ifdef RF_ZERO_GUARD_EN
  localparam bit ZG = 1'b1;
`else
  localparam bit ZG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        v0, v1;
  logic [5:0]  a0, a1;
  logic [31:0] d0, d1;

  logic        o_r0 [2];
  logic        o_r1 [2];
  logic        o_rw [2];
  logic [5:0]  o_wr [2];
  logic [31:0] o_wd [2];
  logic [15:0] o_cnt [2];
  logic [3:0]  a_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic        m_last [2];
  logic        m_rw [2];
  logic [5:0]  m_wr [2];
  logic [31:0] m_wd [2];
  int          m_cnt [2];
  int          cmax [2];
  bit          prio [2];
  logic        sr0 [2];
  logic        sr1 [2];
  exp_t        q0[$];
  exp_t        q1[$];

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .ADDR_W(6), .DATA_W(32), .PRIO_MODE(0), .CNT_W(4)
  ) u_rr (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(o_r0[0]),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(o_r1[0]),
    .reg_write(o_rw[0]), .write_reg(o_wr[0]), .write_data(o_wd[0]),
    .conflict_cnt(a_cnt)
  );
  assign o_cnt[0] = {12'b0, a_cnt};

  rf_write_arbiter #(
    .ADDR_W(6), .DATA_W(32), .PRIO_MODE(1), .CNT_W(16)
  ) u_fp (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(o_r0[1]),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(o_r1[1]),
    .reg_write(o_rw[1]), .write_reg(o_wr[1]), .write_data(o_wd[1]),
    .conflict_cnt(o_cnt[1])
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic f,
                      input logic iv0, input logic [5:0] ia0,
                      input logic [31:0] id0,
                      input logic iv1, input logic [5:0] ia1,
                      input logic [31:0] id1);
    exp_t e;
    @(negedge clk);
    rst = r; flush = f;
    v0 = iv0; a0 = ia0; d0 = id0;
    v1 = iv1; a1 = ia1; d1 = id1;
    #1;
    for (int k = 0; k < 2; k++) begin
      logic w0, w1;
      w0 = 1'b0;
      w1 = 1'b0;
      if (!r && !f) begin
        if (iv0 && iv1) begin
          if (prio[k] || m_last[k]) w0 = 1'b1;
          else                      w1 = 1'b1;
        end else begin
          w0 = iv0;
          w1 = iv1;
        end
      end
      check($sformatf("ready0[%0d]", k), 64'(o_r0[k]), 64'(w0));
      check($sformatf("ready1[%0d]", k), 64'(o_r1[k]), 64'(w1));
      sr0[k] = o_r0[k];
      sr1[k] = o_r1[k];
      if (r) begin
        m_rw[k] = 1'b0; m_wr[k] = '0; m_wd[k] = '0;
        m_cnt[k] = 0; m_last[k] = 1'b1;
      end else begin
        if (iv0 && iv1 && m_cnt[k] < cmax[k]) m_cnt[k]++;
        if (w0 || w1) begin
          m_last[k] = w1;
          m_wr[k] = w1 ? ia1 : ia0;
          m_wd[k] = w1 ? id1 : id0;
          m_rw[k] = !(ZG && m_wr[k] == 6'd0);
        end else begin
          m_rw[k] = 1'b0;
        end
      end
      e.rw = m_rw[k]; e.wr = m_wr[k]; e.wd = m_wd[k];
      e.cnt = 16'(m_cnt[k]);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("sb_depth[%0d]", k),
            64'(k == 0 ? q0.size() : q1.size()), 64'd1);
      if ((k == 0 ? q0.size() : q1.size()) != 0) begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("reg_write[%0d]", k), 64'(o_rw[k]), 64'(e.rw));
        check($sformatf("write_reg[%0d]", k), 64'(o_wr[k]), 64'(e.wr));
        check($sformatf("write_data[%0d]", k), 64'(o_wd[k]), 64'(e.wd));
        check($sformatf("conflict_cnt[%0d]", k), 64'(o_cnt[k]), 64'(e.cnt));
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    v0 = 1'b0; a0 = '0; d0 = '0;
    v1 = 1'b0; a1 = '0; d1 = '0;
    cmax[0] = 15; cmax[1] = 65535;
    prio[0] = 1'b0; prio[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_last[k] = 1'b1; m_rw[k] = 1'b0; m_wr[k] = '0;
      m_wd[k] = '0; m_cnt[k] = 0;
    end

    do_reset(2);
    idle();
    check("rst_rw", 64'(o_rw[0]), 64'd0);
    check("rst_wr", 64'(o_wr[0]), 64'd0);
    check("rst_wd", 64'(o_wd[0]), 64'd0);
    check("rst_cnt", 64'(o_cnt[0]), 64'd0);

    step(1'b0, 1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0, 32'd0);
    check("single_rdy", 64'(sr0[0]), 64'd1);
    check("single_rw", 64'(o_rw[0]), 64'd1);
    check("single_wr", 64'(o_wr[0]), 64'd5);
    check("single_wd", 64'(o_wd[0]), 64'hDEADBEEF);
    idle();
    check("single_rw_off", 64'(o_rw[0]), 64'd0);

    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 6'(10 + i), 32'(100 + i),
           1'b1, 6'(20 + i), 32'(200 + i));
      check("rr_gnt0", 64'(sr0[0]), 64'((i % 2) == 0));
      check("fp_gnt0", 64'(sr0[1]), 64'd1);
    end
    check("rr_cnt4", 64'(o_cnt[0]), 64'd4);
    check("fp_cnt4", 64'(o_cnt[1]), 64'd4);

    step(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd23, 32'd203);
    check("fp_req1_after_drop", 64'(sr1[1]), 64'd1);

    step(1'b0, 1'b1, 1'b0, 6'd0, 32'd0, 1'b1, 6'd7, 32'h77);
    check("flush_rdy1", 64'(sr1[0]), 64'd0);
    check("flush_rw", 64'(o_rw[0]), 64'd0);
    step(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd7, 32'h77);
    check("post_flush_rdy1", 64'(sr1[0]), 64'd1);
    check("post_flush_wr", 64'(o_wr[0]), 64'd7);

    step(1'b0, 1'b0, 1'b1, 6'd0, 32'h1234, 1'b0, 6'd0, 32'd0);
    check("zero_rdy", 64'(sr0[0]), 64'd1);
    check("zero_rw", 64'(o_rw[0]), 64'(!ZG));

    step(1'b0, 1'b0, 1'b1, 6'd9, 32'h99, 1'b0, 6'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    idle();
    check("mid_rst_rw", 64'(o_rw[0]), 64'd0);

    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b0, 1'b1, 6'(i), 32'(i * 3),
           1'b1, 6'(40 + i), 32'(i * 5));
    check("sat_cnt", 64'(o_cnt[0]), 64'd15);

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
           1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the register file's single write port between two writeback requesters. Requester 0 is the ALU writeback path; requester 1 is the load/long-latency unit. Each requester uses a valid/ready handshake. The winning write is registered and presented to the register file's reg_write/write_reg/write_data inputs one cycle later. A saturating counter records write-port conflicts for performance visibility.

Parameters:
ADDR_W, 6, register index width (matches register-file read/write index width)
DATA_W, 32, write data width
PRIO_MODE, 0, 0 = round-robin on conflict; 1 = fixed priority, requester 0 always wins
CNT_W, 16, width of conflict counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  pipeline flush: drop this cycle's grant and cancel the staged write
req0_valid  in  1  ALU writeback request
req0_addr  in  ADDR_W  destination register, requester 0
req0_data  in  DATA_W  write data, requester 0
req0_ready  out  1  requester 0 accepted this cycle
req1_valid  in  1  load-unit writeback request
req1_addr  in  ADDR_W  destination register, requester 1
req1_data  in  DATA_W  write data, requester 1
req1_ready  out  1  requester 1 accepted this cycle
reg_write  out  1  register-file write enable (registered)
write_reg  out  ADDR_W  register-file write index (registered)
write_data  out  DATA_W  register-file write data (registered)
conflict_cnt  out  CNT_W  cycles in which both requesters were valid

Behaviour:
- Transfer on reqN: reqN_valid & reqN_ready at a rising edge.
- reqN_ready is combinational from the valid inputs, last_grant, PRIO_MODE and flush.
- Requesters hold addr/data stable while valid & !ready. The arbiter does not buffer unaccepted requests.
- At most one ready per cycle. ready is never asserted without the matching valid.
- Grant rules, flush=0:
  - Only req0 valid -> grant 0.
  - Only req1 valid -> grant 1.
  - Neither valid -> no grant.
  - Both valid, PRIO_MODE=1 -> grant 0.
  - Both valid, PRIO_MODE=0 -> grant the requester not in last_grant.
- last_grant is a 1-bit register. It updates to the granted index on every transfer and holds otherwise.
- Equal addresses on both requesters get no special handling: the requests are serialized per the grant rules. The later write wins in the register file.
- Output stage, updated every edge:
  - On transfer: reg_write=1; write_reg/write_data take the granted addr/data.
  - With no transfer: reg_write=0; write_reg/write_data hold their previous values.
  - Latency from accepted request to reg_write high is exactly 1 cycle. Sustained throughput is 1 write/cycle.
- flush=1:
  - Both readies are 0.
  - The next-cycle reg_write is 0.
  - last_grant holds.
  - A write already on the outputs in the flush cycle completes; flush affects only the next edge.
- conflict_cnt increments by 1 on every edge where req0_valid & req1_valid, including flush cycles. It saturates at all-ones and does not wrap.
- Reset, rst=1 at an edge:
  - reg_write=0, write_reg=0, write_data=0, conflict_cnt=0.
  - last_grant=1, so req0 wins the first round-robin tie.
  - Readies are 0 during reset cycles.
  - Reset mid-operation discards any staged write. No write is issued in the cycle after reset.
- No state machine beyond last_grant, the output register and the counter. All state is fully synchronous.

Optional Feature:
Macro: RF_ZERO_GUARD_EN.
- Defined: a transfer whose addr is 0 is accepted (ready asserted, last_grant updated as normal), but reg_write stays 0 in the next cycle, so register 0 is never written.
- Not defined: writes to address 0 pass through like any other address.

Test Plan:
- Reset with rst=1 for 2 cycles, then release -> reg_write=0, write_reg=0, write_data=0, conflict_cnt=0 on the first cycle after release.
- req0 only, addr=5, data=0xDEADBEEF -> req0_ready=1 same cycle; next cycle reg_write=1, write_reg=5, write_data=0xDEADBEEF; the following cycle reg_write=0.
- Both valid for 4 cycles, PRIO_MODE=0, starting from reset -> grants alternate 0,1,0,1 (each requester re-presents a new request after acceptance); conflict_cnt=4.
- Same stimulus with PRIO_MODE=1, req1 held valid -> req1_ready=0 while req0 valid; req1 granted in the first cycle req0 drops.
- flush=1 with req1 valid, addr=7 -> req1_ready=0; next cycle reg_write=0; last_grant unchanged; req1 granted the cycle after flush drops.
- RF_ZERO_GUARD_EN defined, req0 addr=0, data=0x1234 -> req0_ready=1, next cycle reg_write=0. Without the macro, reg_write=1, write_reg=0. Also force conflict_cnt to saturation with CNT_W=4 -> holds at 15.
